// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants used by the receiver,
//                the pulse generator and the receive-side byte buffer.
//  Contents    : uart_byte_t     - one UART data byte
//                UartOversample  - receiver oversampling ratio
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int UartOversample = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side circular byte buffer placed after uart_rx.
//                Every in_valid strobe is captured while room exists; the
//                receiver cannot be stalled, so bytes arriving while the
//                buffer is full are dropped and flagged in a sticky bit.
//                Bytes leave over a ready/valid stream with the head entry
//                read combinationally from the read pointer.
//  Ports       : clk            - system clock
//                rst            - asynchronous active-low reset
//                in_data        - byte from uart_rx
//                in_valid       - write strobe (level, one byte per cycle)
//                out_data       - byte at head of buffer
//                out_valid      - out_data holds a valid byte
//                out_ready      - consumer accepts out_data this cycle
//                count          - bytes currently stored, 0..DEPTH
//                overflow       - sticky: a byte was dropped while full
//                clear_overflow - synchronous clear of overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,   // power of two, minimum 2
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int c_AW = $clog2(DEPTH);

    // Pointers carry one bit beyond the address so full and empty differ.
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               r_overflow;

    logic [c_AW:0]      w_count;
    logic               w_full;
    logic               w_rd;
    logic               w_wr;
    logic               w_drop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    // count never exceeds DEPTH, so its MSB is set only when full.
    assign w_full  = w_count[c_AW];
    assign w_rd    = (w_count != '0) && out_ready;
    // A read on the same edge frees the slot the write needs.
    assign w_wr    = in_valid && (!w_full || w_rd);
    assign w_drop  = in_valid && !w_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= in_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign out_data  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign out_valid = (w_count != '0);
    assign count     = w_count;
    assign overflow  = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based model
//                tracks buffer contents and the sticky overflow flag; every
//                falling edge compares the DUT outputs against it. Directed
//                sequences add literal expectations for key values.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most DEPTH bytes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf <= 1'b0;
        end else begin
            automatic bit rd = (mq.size() > 0) && out_ready;
            automatic bit wr = in_valid && ((mq.size() < DEPTH) || rd);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(in_data);
            if (in_valid && !wr) m_ovf <= 1'b1;
            else if (clear_overflow) m_ovf <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end

    // Apply one cycle of stimulus; returns at the following falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        in_valid       = v;
        in_data        = d;
        out_ready      = rdy;
        clear_overflow = clr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // stays_in_reset
        @(negedge clk);
        for (int i = 0; i < 3000; i++) cyc(i[0], 8'hA5, 1'b0, 1'b0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // single_byte_latency
        cyc(1'b1, 8'hD5, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hD5);
        chk("single_count", 32'(count), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_hold", 32'(out_data), 32'hD5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_drain_valid", 32'(out_valid), 32'h0);
        chk("single_drain_count", 32'(count), 32'h0);

        // fill_and_drain_order, two passes across the wrap
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) cyc(1'b1, 8'(p * 16 + i), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'd16);
            chk("fill_ovf", 32'(overflow), 32'h0);
            for (int i = 0; i < 16; i++) begin
                chk("drain_order", 32'(out_data), 32'(p * 16 + i));
                cyc(1'b0, 8'h00, 1'b1, 1'b0);
            end
            chk("drain_empty", 32'(out_valid), 32'h0);
        end

        // overflow_drop_and_clear
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_head", 32'(out_data), 32'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'h0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear2", 32'(overflow), 32'h0);

        // full_simultaneous_rw
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_rw_ovf", 32'(overflow), 32'h0);
        chk("full_rw_count", 32'(count), 32'd16);
        for (int i = 1; i < 16; i++) begin
            chk("full_rw_order", 32'(out_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("full_rw_last", 32'(out_data), 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rw_empty", 32'(count), 32'h0);

        // simultaneous read/write on empty, then on non-empty
        cyc(1'b1, 8'h42, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count), 32'h1);
        chk("empty_rw_data", 32'(out_data), 32'h42);
        cyc(1'b1, 8'h5B, 1'b1, 1'b0);
        chk("ne_rw_count", 32'(count), 32'h1);
        chk("ne_rw_data", 32'(out_data), 32'h5B);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // receiver-paced bytes, one per 160-cycle frame
        cyc(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 159; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'hC5, 1'b0, 1'b0);
        chk("frames_count", 32'(count), 32'h2);
        chk("frames_first", 32'(out_data), 32'hD5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("frames_second", 32'(out_data), 32'hC5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-operation, asserted between edges
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
